// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between a FIFO client and fifo_ctrl.
// master = client side (drives requests), slave = controller side.
interface fifo_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              wr_req;
  logic              rd_req;
  logic              flush;
  logic              clr_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_req, rd_req, flush, clr_err,
    input  wr_en, wr_addr, rd_en, rd_addr, rd_valid, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req, flush, clr_err,
    output wr_en, wr_addr, rd_en, rd_addr, rd_valid, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for an external synchronous dual-port RAM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Optional feature: define FIFO_CTRL_ALMOST_EN to enable almost_full /
// almost_empty thresholds; otherwise both outputs are tied low.
module fifo_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  fifo_ctrl_if.slave bus
);

  localparam int PW     = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int STAGES = 1;            // RAM read latency

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [STAGES:0]   vld_pipe;
  logic              overflow;
  logic              underflow;

  logic              full;
  logic              empty;
  logic [PW-1:0]     count;
  logic              wr_en;
  logic              rd_en;
  logic              ovf_evt;
  logic              udf_evt;

  // Occupancy flags straight from the pointers; wrap bit separates full from empty.
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
            (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    count = wptr - rptr;
  end

  // Accept decisions use pre-cycle flags, so there is no fall-through at
  // empty and no write-through at full. Reset and flush block all RAM traffic.
  always_comb begin
    wr_en   = n_rst && bus.wr_req && !full  && !bus.flush;
    rd_en   = n_rst && bus.rd_req && !empty && !bus.flush;
    ovf_evt = bus.wr_req && full  && !bus.flush;
    udf_evt = bus.rd_req && empty && !bus.flush;
  end

  // Pointer update: flush returns both to zero, otherwise step by accepted transfers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

  // Read-valid delay line matching the RAM read latency.
  assign vld_pipe[0] = rd_en;
  always_ff @(posedge clk) begin
    if (!n_rst) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)          overflow  <= 1'b1;
      else if (bus.clr_err) overflow  <= 1'b0;
      if (udf_evt)          underflow <= 1'b1;
      else if (bus.clr_err) underflow <= 1'b0;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  logic [PW-1:0] free_slots;

  // Threshold flags from registered occupancy only.
  always_comb begin
    free_slots       = PW'(DEPTH) - count;
    bus.almost_full  = (int'(free_slots) <= AF_MARGIN);
    bus.almost_empty = (int'(count) <= AE_MARGIN);
  end
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

  assign bus.wr_en     = wr_en;
  assign bus.rd_en     = rd_en;
  assign bus.wr_addr   = wptr[ADDR_W-1:0];
  assign bus.rd_addr   = rptr[ADDR_W-1:0];
  assign bus.rd_valid  = vld_pipe[STAGES];
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

  // Structural invariants of the pointer pair.
  a_not_full_empty: assert property (@(posedge clk) disable iff (!n_rst)
    !(full && empty));
  a_count_range: assert property (@(posedge clk) disable iff (!n_rst)
    count <= PW'(DEPTH));
  a_no_ram_in_flush: assert property (@(posedge clk) disable iff (!n_rst)
    bus.flush |-> !(wr_en || rd_en));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed + randomized bench for fifo_ctrl with an occupancy
// model (push/pop totals and a count) checked on every falling edge.
module tb_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef FIFO_CTRL_ALMOST_EN
  localparam int ALM = 1;
`else
  localparam int ALM = 0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fifo_ctrl_if #(.ADDR_W(AW)) bus ();

  fifo_ctrl #(.ADDR_W(AW), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as a plain integer, addresses from total
  // accepted pushes/pops since the last reset or flush.
  int  m_occ = 0, m_wtot = 0, m_rtot = 0;
  bit  m_rv = 0, m_ovf = 0, m_udf = 0, armed = 0;

  always @(negedge clk) begin
    bit m_full, m_empty, e_wen, e_ren;
    int e_af, e_ae;
    m_full  = (m_occ == DEPTH);
    m_empty = (m_occ == 0);
    e_wen   = n_rst && bus.wr_req && !m_full  && !bus.flush;
    e_ren   = n_rst && bus.rd_req && !m_empty && !bus.flush;
    e_af    = ALM ? int'((DEPTH - m_occ) <= 2) : 0;
    e_ae    = ALM ? int'(m_occ <= 2) : 0;
    if (!n_rst) begin
      chk("m_wr_en_rst", int'(bus.wr_en), 0);
      chk("m_rd_en_rst", int'(bus.rd_en), 0);
    end else if (armed) begin
      chk("m_wr_en", int'(bus.wr_en), int'(e_wen));
      chk("m_rd_en", int'(bus.rd_en), int'(e_ren));
      if (e_wen) chk("m_wr_addr", int'(bus.wr_addr), m_wtot % DEPTH);
      if (e_ren) chk("m_rd_addr", int'(bus.rd_addr), m_rtot % DEPTH);
      chk("m_count",     int'(bus.count),        m_occ);
      chk("m_full",      int'(bus.full),         int'(m_full));
      chk("m_empty",     int'(bus.empty),        int'(m_empty));
      chk("m_rd_valid",  int'(bus.rd_valid),     int'(m_rv));
      chk("m_overflow",  int'(bus.overflow),     int'(m_ovf));
      chk("m_underflow", int'(bus.underflow),    int'(m_udf));
      chk("m_almost_full",  int'(bus.almost_full),  e_af);
      chk("m_almost_empty", int'(bus.almost_empty), e_ae);
    end
    // advance model to the state after the coming rising edge
    if (!n_rst) begin
      m_occ = 0; m_wtot = 0; m_rtot = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
      armed = 1;
    end else begin
      m_rv = e_ren;
      if (bus.wr_req && m_full && !bus.flush)       m_ovf = 1;
      else if (bus.clr_err)                         m_ovf = 0;
      if (bus.rd_req && m_empty && !bus.flush)      m_udf = 1;
      else if (bus.clr_err)                         m_udf = 0;
      if (bus.flush) begin
        m_occ = 0; m_wtot = 0; m_rtot = 0;
      end else begin
        m_occ  = m_occ + int'(e_wen) - int'(e_ren);
        m_wtot = (m_wtot + int'(e_wen)) % (2 * DEPTH);
        m_rtot = (m_rtot + int'(e_ren)) % (2 * DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input bit r, input bit f, input bit c);
    bus.wr_req = w; bus.rd_req = r; bus.flush = f; bus.clr_err = c;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin drive(1, 0, 0, 0); step(); end
    drive(0, 0, 0, 0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 1, 0, 0); step(); end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    n_rst = 1'b0;
    step(); step();
    n_rst = 1'b1;
    // reset state
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);
    chk("rst_udf",   int'(bus.underflow), 0);
    chk("rst_rv",    int'(bus.rd_valid), 0);
    chk("rst_ae",    int'(bus.almost_empty), ALM);
    chk("rst_af",    int'(bus.almost_full), 0);

    // fill
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0); #1;
      chk("fill_wr_en", int'(bus.wr_en), 1);
      chk("fill_wr_addr", int'(bus.wr_addr), i);
      step();
    end
    chk("fill_count", int'(bus.count), 8);
    chk("fill_full",  int'(bus.full), 1);
    chk("fill_empty", int'(bus.empty), 0);
    chk("fill_ovf",   int'(bus.overflow), 0);
    drive(1, 0, 0, 0); #1;
    chk("ovf_wr_en", int'(bus.wr_en), 0);
    step();
    chk("ovf_set", int'(bus.overflow), 1);

    // drain
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0); #1;
      chk("drain_rd_en", int'(bus.rd_en), 1);
      chk("drain_rd_addr", int'(bus.rd_addr), i);
      step();
      chk("drain_rd_valid", int'(bus.rd_valid), 1);
    end
    chk("drain_empty", int'(bus.empty), 1);
    drive(0, 1, 0, 0); #1;
    chk("udf_rd_en", int'(bus.rd_en), 0);
    step();
    chk("udf_set", int'(bus.underflow), 1);
    chk("udf_rd_valid", int'(bus.rd_valid), 0);
    drive(0, 0, 0, 1); step(); drive(0, 0, 0, 0);
    chk("clr_ovf", int'(bus.overflow), 0);
    chk("clr_udf", int'(bus.underflow), 0);

    // simultaneous at count 0, 8, 4
    drive(1, 1, 0, 0); #1;
    chk("sim0_wr_en", int'(bus.wr_en), 1);
    chk("sim0_rd_en", int'(bus.rd_en), 0);
    step();
    chk("sim0_count", int'(bus.count), 1);
    push_n(7);
    drive(1, 1, 0, 0); #1;
    chk("sim8_wr_en", int'(bus.wr_en), 0);
    chk("sim8_rd_en", int'(bus.rd_en), 1);
    step();
    chk("sim8_count", int'(bus.count), 7);
    pop_n(3);
    drive(1, 1, 0, 0); step();
    chk("sim4_count", int'(bus.count), 4);

    // clr_err against a fresh overflow
    push_n(4);
    drive(1, 0, 0, 1); step();
    chk("clr_vs_ovf", int'(bus.overflow), 1);
    drive(0, 0, 0, 1); step();
    chk("clr_after", int'(bus.overflow), 0);

    // flush at count 5
    drive(0, 0, 1, 0); step();
    push_n(5);
    chk("pre_flush_count", int'(bus.count), 5);
    drive(1, 1, 1, 0); #1;
    chk("flush_wr_en", int'(bus.wr_en), 0);
    chk("flush_rd_en", int'(bus.rd_en), 0);
    step();
    drive(0, 0, 0, 0);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_empty", int'(bus.empty), 1);

    // reset mid-operation at count 3
    push_n(3);
    n_rst = 1'b0; drive(1, 0, 0, 0); #1;
    chk("rst_mid_wr_en", int'(bus.wr_en), 0);
    step();
    n_rst = 1'b1; drive(0, 0, 0, 0);
    chk("rst_mid_count", int'(bus.count), 0);

    // almost thresholds
    push_n(2); chk("ae_at2", int'(bus.almost_empty), ALM);
    push_n(1); chk("ae_at3", int'(bus.almost_empty), 0);
    push_n(2); chk("af_at5", int'(bus.almost_full), 0);
    push_n(1); chk("af_at6", int'(bus.almost_full), ALM);

    // wrap-around with interleaved pairs at count 1
    drive(0, 0, 1, 0); step();
    push_n(1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0); #1;
      chk("wrap_wr_addr", int'(bus.wr_addr), (i + 1) % 8);
      chk("wrap_rd_addr", int'(bus.rd_addr), i % 8);
      step();
    end
    drive(0, 0, 0, 0);
    chk("wrap_count", int'(bus.count), 1);

    // randomized phases: write-heavy, read-heavy, balanced
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 400; i++) begin
        n_rst = ($urandom_range(0, 199) != 0);
        drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        step();
      end
    end
    n_rst = 1'b1;
    drive(0, 0, 0, 0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
